// File: rtl/column_hit_pkg.sv
// Shared constants, FSM encoding and decoded-hit layout for the column hit receiver.
package column_hit_pkg;

  localparam int TOA_MSB  = 25;
  localparam int TOA_LSB  = 17;
  localparam int FTOA_MSB = 16;
  localparam int FTOA_LSB = 12;
  localparam int TOT_MSB  = 11;
  localparam int TOT_LSB  = 4;
  localparam int PIX_MSB  = 3;
  localparam int PIX_LSB  = 0;

  localparam int ARB_W  = 26;
  localparam int TOA_W  = 9;
  localparam int FTOA_W = 5;
  localparam int TOT_W  = 8;
  localparam int PIX_W  = 4;
  localparam int FINE_W = 13;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [TOA_W-1:0]  toa;
    logic [FTOA_W-1:0] ftoa;
    logic [TOT_W-1:0]  tot;
    logic [PIX_W-1:0]  pix;
    logic [FINE_W-1:0] fine_time;
    logic              ftoa_err;
  } hit_entry_t;

  localparam int ENTRY_W = $bits(hit_entry_t);

endpackage

// File: rtl/hit_word_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
module hit_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == DEPTH_L);
  assign valid   = (level != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  // Head is forced to zero while empty so downstream never sees stale data.
  assign dout    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/column_hit_receiver.sv
// Periphery end of the super-pixel arbiter chain: four-phase handshake, Gray
// TOA decode, fine-time computation and FWFT buffering toward column readout.
module column_hit_receiver
  import column_hit_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FTOA_MAX   = 16
) (
  input  logic                          clk_40MHz,
  input  logic                          rst,
  input  logic [ARB_W-1:0]              arbiter_data,
  input  logic                          shake_hands_last,
  output logic                          shake_hands_next,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TOA_W-1:0]              out_toa,
  output logic [FTOA_W-1:0]             out_ftoa,
  output logic [TOT_W-1:0]              out_tot,
  output logic [PIX_W-1:0]              out_pix,
  output logic [FINE_W-1:0]             out_fine_time,
  output logic                          out_ftoa_err,
  output logic [15:0]                   hit_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output rx_state_t                     dbg_state
);

  // Handshake: shake_hands_last high means arbiter_data is stable; a hit is
  // captured once per rising request (only when the FIFO has room), the
  // registered ack then stays high until the request is seen low.
  // Downstream: an entry moves when out_valid && out_ready on a rising edge.

  rx_state_t         state, state_next;
  logic              capture;
  logic              fifo_full;
  logic [TOA_W-1:0]  toa_gray;
  logic [TOA_W-1:0]  toa_bin;
  logic [FTOA_W-1:0] ftoa;
  hit_entry_t        wr_entry;
  hit_entry_t        rd_entry;
  logic [ENTRY_W-1:0] rd_word;

  assign toa_gray = arbiter_data[TOA_MSB:TOA_LSB];
  assign ftoa     = arbiter_data[FTOA_MSB:FTOA_LSB];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    toa_bin = '0;
    for (int i = 0; i < TOA_W; i++) begin
      toa_bin[i] = ^(toa_gray >> i);
    end
  end

  always_comb begin
    wr_entry           = '0;
    wr_entry.toa       = toa_bin;
    wr_entry.ftoa      = ftoa;
    wr_entry.tot       = arbiter_data[TOT_MSB:TOT_LSB];
    wr_entry.pix       = arbiter_data[PIX_MSB:PIX_LSB];
    wr_entry.fine_time = {toa_bin, 4'b0000} - FINE_W'(ftoa);
    wr_entry.ftoa_err  = (int'(ftoa) > FTOA_MAX);
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (shake_hands_last && !fifo_full) begin
          capture    = 1'b1;
          state_next = ACK;
        end
      end
      ACK:      state_next = WAIT_LOW;
      WAIT_LOW: if (!shake_hands_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      state            <= IDLE;
      shake_hands_next <= 1'b0;
      hit_count        <= '0;
    end else begin
      state            <= state_next;
      shake_hands_next <= (state_next != IDLE);
      if (capture && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
  end

  assign dbg_state = state;

  hit_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_40MHz),
    .rst   (rst),
    .push  (capture),
    .din   (wr_entry),
    .pop   (out_valid && out_ready),
    .dout  (rd_word),
    .valid (out_valid),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign rd_entry      = rd_word;
  assign out_toa       = rd_entry.toa;
  assign out_ftoa      = rd_entry.ftoa;
  assign out_tot       = rd_entry.tot;
  assign out_pix       = rd_entry.pix;
  assign out_fine_time = rd_entry.fine_time;
  assign out_ftoa_err  = rd_entry.ftoa_err;

endmodule

// File: tb/tb_column_hit_receiver.sv
// Bench for column_hit_receiver: handshake driver, reference model, scoreboard on pops.
module tb_column_hit_receiver;
  import column_hit_pkg::*;

  localparam int DEPTH = 8;

  logic        clk_40MHz = 1'b0;
  logic        rst;
  logic [25:0] arbiter_data;
  logic        shake_hands_last;
  logic        shake_hands_next;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_toa;
  logic [4:0]  out_ftoa;
  logic [7:0]  out_tot;
  logic [3:0]  out_pix;
  logic [12:0] out_fine_time;
  logic        out_ftoa_err;
  logic [15:0] hit_count;
  logic [3:0]  fifo_level;
  rx_state_t   dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int exp_hits = 0;
  int ready_mode = 0;
  logic manual_ready = 1'b0;
  logic [39:0] exp_q[$];

  column_hit_receiver #(.FIFO_DEPTH(DEPTH), .FTOA_MAX(16)) dut (
    .clk_40MHz        (clk_40MHz),
    .rst              (rst),
    .arbiter_data     (arbiter_data),
    .shake_hands_last (shake_hands_last),
    .shake_hands_next (shake_hands_next),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_toa          (out_toa),
    .out_ftoa         (out_ftoa),
    .out_tot          (out_tot),
    .out_pix          (out_pix),
    .out_fine_time    (out_fine_time),
    .out_ftoa_err     (out_ftoa_err),
    .hit_count        (hit_count),
    .fifo_level       (fifo_level),
    .dbg_state        (dbg_state)
  );

  // Clock / reset-independent infrastructure
  always #5 clk_40MHz = ~clk_40MHz;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Downstream ready: 0 = hold off, 1 = random, 2 = always, 3 = manual
  always @(posedge clk_40MHz) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b1;
      default: out_ready = manual_ready;
    endcase
  end

  // Reference model: straight from the field definitions
  function automatic logic [39:0] model(input logic [25:0] d);
    logic [8:0] g, bin;
    logic [4:0] f;
    int fine;
    g = d[25:17];
    f = d[16:12];
    bin = g;
    for (int s = 1; s < 9; s++) bin = bin ^ (g >> s);
    fine = ((int'(bin) * 16 - int'(f)) % 8192 + 8192) % 8192;
    return {bin, f, d[11:4], d[3:0], 13'(fine), (int'(f) > 16)};
  endfunction

  function automatic logic [25:0] word(input logic [8:0] g, input logic [4:0] f,
                                       input logic [7:0] t, input logic [3:0] p);
    return {g, f, t, p};
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: compare every entry that leaves the FIFO
  always @(negedge clk_40MHz) begin
    logic [39:0] got, exp;
    if (!rst && out_valid && out_ready) begin
      got = {out_toa, out_ftoa, out_tot, out_pix, out_fine_time, out_ftoa_err};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pop: got %h expected nothing", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          miscompares++;
          $display("FAIL pop_entry: got %h expected %h", got, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_40MHz);
    #1;
  endtask

  // Driver: one full four-phase handshake; hold = cycles request stays high after ack
  task automatic send_hit(input logic [25:0] d, input int hold);
    int cnt;
    logic was_full;
    was_full = (fifo_level == 4'(DEPTH));
    arbiter_data = d;
    shake_hands_last = 1'b1;
    exp_q.push_back(model(d));
    exp_hits++;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!shake_hands_next && cnt < 100);
    if (!shake_hands_next) begin
      check("ack_timeout", 0, 1);
      shake_hands_last = 1'b0;
      return;
    end
    if (!was_full) check("ack_latency", cnt, 1);
    repeat (hold) tick();
    shake_hands_last = 1'b0;
    tick();
    if (hold == 0) begin
      check("ack_held_after_early_drop", shake_hands_next, 1);
      tick();
    end
    check("ack_fall", shake_hands_next, 0);
    check("hit_count", hit_count, exp_hits);
    arbiter_data = 26'($urandom);
  endtask

  task automatic drain();
    int cnt;
    ready_mode = 2;
    cnt = 0;
    while ((exp_q.size() != 0 || fifo_level != 0) && cnt < 100) begin
      tick();
      cnt++;
    end
    check("drain_level", fifo_level, 0);
    check("drain_queue", exp_q.size(), 0);
    ready_mode = 0;
    tick();
  endtask

  task automatic check_head(input int toa, input int fine, input int err,
                            input int tot, input int pix);
    check("head_valid", out_valid, 1);
    check("head_toa", out_toa, toa);
    check("head_fine_time", out_fine_time, fine);
    check("head_ftoa_err", out_ftoa_err, err);
    check("head_tot", out_tot, tot);
    check("head_pix", out_pix, pix);
  endtask

  initial begin
    logic [25:0] d;
    int cnt;
    rst = 1'b1;
    shake_hands_last = 1'b0;
    arbiter_data = '0;
    repeat (3) tick();
    check("rst_ack", shake_hands_next, 0);
    check("rst_valid", out_valid, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_level", fifo_level, 0);
    check("rst_toa", out_toa, 0);
    check("rst_fine_time", out_fine_time, 0);
    rst = 1'b0;
    tick();

    // Directed decode cases
    send_hit(word(9'b000000111, 5'd3, 8'd20, 4'b0101), 1);
    check("level_one", fifo_level, 1);
    check_head(5, 77, 0, 20, 5);
    drain();
    send_hit(word(9'b100000000, 5'd0, 8'd200, 4'b1010), 2);
    check_head(511, 8176, 0, 200, 10);
    drain();
    send_hit(word(9'd0, 5'd1, 8'd1, 4'd0), 1);
    check_head(0, 8191, 0, 1, 0);
    drain();
    send_hit(word(9'd0, 5'd17, 8'd7, 4'd15), 1);
    check_head(0, 8175, 1, 7, 15);
    drain();

    // Fill the FIFO, then hold a ninth request against backpressure
    for (int i = 0; i < DEPTH; i++) send_hit(26'($urandom), int'($urandom_range(0, 2)));
    check("full_level", fifo_level, DEPTH);
    d = 26'($urandom);
    arbiter_data = d;
    shake_hands_last = 1'b1;
    exp_q.push_back(model(d));
    exp_hits++;
    repeat (5) tick();
    check("full_no_ack", shake_hands_next, 0);
    check("full_level_held", fifo_level, DEPTH);
    check("full_no_count", hit_count, exp_hits - 1);
    ready_mode = 3;
    manual_ready = 1'b1;
    tick();
    manual_ready = 1'b0;
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!shake_hands_next && cnt < 20);
    check("ack_after_pop", shake_hands_next, 1);
    check("ack_after_pop_cycles", cnt, 1);
    check("level_refilled", fifo_level, DEPTH);
    check("count_after_pop", hit_count, exp_hits);
    shake_hands_last = 1'b0;
    tick();
    tick();
    check("ninth_ack_fall", shake_hands_next, 0);
    drain();

    // Early drop during ACK and long hold in WAIT_LOW
    send_hit(26'($urandom), 0);
    send_hit(26'($urandom), 4);
    drain();

    // Random traffic with random downstream stalls
    ready_mode = 1;
    repeat (40) begin
      d = 26'($urandom);
      if ($urandom_range(0, 3) == 0) d[16:12] = 5'(16 + $urandom_range(0, 2));
      send_hit(d, int'($urandom_range(0, 3)));
      ready_mode = 1;
    end
    drain();

    // Reset in WAIT_LOW with three entries queued
    for (int i = 0; i < 3; i++) send_hit(26'($urandom), 1);
    d = 26'($urandom);
    arbiter_data = d;
    shake_hands_last = 1'b1;
    tick();
    tick();
    check("pre_rst_level", fifo_level, 4);
    check("pre_rst_ack", shake_hands_next, 1);
    rst = 1'b1;
    tick();
    exp_q.delete();
    exp_hits = 0;
    check("mid_rst_ack", shake_hands_next, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_count", hit_count, 0);
    rst = 1'b0;
    exp_q.push_back(model(d));
    exp_hits = 1;
    tick();
    check("post_rst_capture_ack", shake_hands_next, 1);
    check("post_rst_count", hit_count, 1);
    shake_hands_last = 1'b0;
    tick();
    tick();
    check("post_rst_ack_fall", shake_hands_next, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
